// File: rtl/rc_step_sequencer.sv
// Step-response sequencer for the RC filter model: holds the model in reset, applies a
// latched step on v_in, then counts cycles until v_out crosses a latched threshold.
module rc_step_sequencer #(
   parameter int WIDTH      = 18,
   parameter int EXP        = -12,
   parameter int RST_CYCLES = 4,
   parameter int TIMEOUT    = 1000,
   parameter int CNT_W      = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    abort,
   input  logic signed [WIDTH-1:0] v_step,
   input  logic signed [WIDTH-1:0] v_thresh,
   input  logic signed [WIDTH-1:0] v_out,
   output logic signed [WIDTH-1:0] v_in,
   output logic                    model_rst,
   output logic                    busy,
   output logic                    done,
   output logic                    timeout,
   output logic                    meas_valid,
   output logic [CNT_W-1:0]        settle_cycles
);

   localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_TMO   = CNT_W'(TIMEOUT);

   // EXP only fixes the real-number interpretation; raw integers are compared.
   if (RST_CYCLES < 1 || TIMEOUT < 1 || TIMEOUT >= (1 << CNT_W) || EXP >= WIDTH) begin : g_bad_params
      $error("rc_step_sequencer: invalid parameter set");
   end

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RST_HOLD = 2'd1,
      STEP     = 2'd2,
      DONE     = 2'd3
   } state_t;

   state_t                  state;
   logic [HOLD_W-1:0]       hold_cnt;
   logic [CNT_W-1:0]        cnt;
   logic signed [WIDTH-1:0] step_q;
   logic signed [WIDTH-1:0] thresh_q;
   logic                    dir_up;
   logic                    crossed;

   always_comb begin
      crossed = dir_up ? (v_out >= thresh_q) : (v_out <= thresh_q);
   end

   // Single registered FSM; every output is updated on the transition into its state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         hold_cnt      <= '0;
         cnt           <= '0;
         step_q        <= '0;
         thresh_q      <= '0;
         dir_up        <= 1'b0;
         v_in          <= '0;
         model_rst     <= 1'b1;
         busy          <= 1'b0;
         done          <= 1'b0;
         timeout       <= 1'b0;
         meas_valid    <= 1'b0;
         settle_cycles <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  step_q        <= v_step;
                  thresh_q      <= v_thresh;
                  dir_up        <= (v_step >= v_thresh);
                  meas_valid    <= 1'b0;
                  timeout       <= 1'b0;
                  settle_cycles <= '0;
                  hold_cnt      <= '0;
                  busy          <= 1'b1;
                  state         <= RST_HOLD;
               end
            end
            RST_HOLD: begin
               if (abort) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= '0;
                  if (hold_cnt == HOLD_LAST) begin
                     model_rst <= 1'b0;
                     v_in      <= step_q;
                     state     <= STEP;
                  end else begin
                     hold_cnt <= hold_cnt + HOLD_W'(1);
                  end
               end
            end
            STEP: begin
               // Abort outranks a crossing or timeout seen on the same edge.
               if (abort) begin
                  model_rst <= 1'b1;
                  v_in      <= '0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else if (crossed || cnt == CNT_LAST) begin
                  settle_cycles <= crossed ? cnt : CNT_TMO;
                  timeout       <= !crossed;
                  done          <= 1'b1;
                  meas_valid    <= 1'b1;
                  model_rst     <= 1'b1;
                  v_in          <= '0;
                  state         <= DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rc_step_sequencer.sv
// Directed bench for rc_step_sequencer driven by a ramp stub standing in for the RC model.
module tb_rc_step_sequencer;

   logic               clk;
   logic               rst;
   logic               start;
   logic               abort;
   logic signed [17:0] v_step;
   logic signed [17:0] v_thresh;
   logic signed [17:0] v_out;
   logic signed [17:0] v_in;
   logic               model_rst;
   logic               busy;
   logic               done;
   logic               timeout;
   logic               meas_valid;
   logic [15:0]        settle_cycles;

   logic [1:0]         mode;
   logic signed [17:0] ramp;
   int                 checks;
   int                 errors;

   rc_step_sequencer #(
      .WIDTH(18), .EXP(-12), .RST_CYCLES(4), .TIMEOUT(1000), .CNT_W(16)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .v_step(v_step), .v_thresh(v_thresh), .v_out(v_out),
      .v_in(v_in), .model_rst(model_rst), .busy(busy), .done(done),
      .timeout(timeout), .meas_valid(meas_valid), .settle_cycles(settle_cycles)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model stub: mode 0 ramps up from 0, mode 1 ramps down from 4096, mode 2 holds 0.
   always_ff @(posedge clk) begin
      if (model_rst) ramp <= '0;
      else           ramp <= ramp + 18'sd64;
   end

   always_comb begin
      v_out = '0;
      case (mode)
         2'd0:    v_out = ramp;
         2'd1:    v_out = 18'sd4096 - ramp;
         default: v_out = '0;
      endcase
   end

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic do_start(input logic signed [17:0] s, input logic signed [17:0] t);
      v_step   = s;
      v_thresh = t;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_hold(output int h);
      h = 0;
      while (model_rst === 1'b1 && h < 20) begin
         h++;
         @(negedge clk);
      end
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 1200) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({model_rst, busy, done, timeout, meas_valid} !== 5'b10000) begin
         errors++;
         $display("[TB] FAIL reset_flags got %b want 10000", {model_rst, busy, done, timeout, meas_valid});
      end
      checks++;
      if (v_in !== 18'sd0 || settle_cycles !== 16'd0) begin
         errors++;
         $display("[TB] FAIL reset_values got v_in=%0d settle=%0d want 0 0", v_in, settle_cycles);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({model_rst, busy} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL reset_idle got %b want 10", {model_rst, busy});
      end
   endtask

   task automatic test_rising();
      int h, n;
      mode = 2'd0;
      do_start(18'sd4096, 18'sd2048);
      checks++;
      if ({model_rst, busy, meas_valid} !== 3'b110) begin
         errors++;
         $display("[TB] FAIL rise_accept got %b want 110", {model_rst, busy, meas_valid});
      end
      wait_hold(h);
      checks++;
      if (h !== 4) begin
         errors++;
         $display("[TB] FAIL rise_hold got %0d want 4", h);
      end
      checks++;
      if (v_in !== 18'sd4096) begin
         errors++;
         $display("[TB] FAIL rise_vin got %0d want 4096", v_in);
      end
      wait_done(n);
      checks++;
      if (n !== 33) begin
         errors++;
         $display("[TB] FAIL rise_latency got %0d want 33", n);
      end
      checks++;
      if (settle_cycles !== 16'd32) begin
         errors++;
         $display("[TB] FAIL rise_settle got %0d want 32", settle_cycles);
      end
      checks++;
      if ({done, timeout, meas_valid, busy, model_rst} !== 5'b10111 || v_in !== 18'sd0) begin
         errors++;
         $display("[TB] FAIL rise_done got %b v_in=%0d want 10111 0", {done, timeout, meas_valid, busy, model_rst}, v_in);
      end
      @(negedge clk);
      checks++;
      if ({done, busy, meas_valid, model_rst} !== 4'b0011) begin
         errors++;
         $display("[TB] FAIL rise_after got %b want 0011", {done, busy, meas_valid, model_rst});
      end
   endtask

   task automatic test_falling();
      int h, n;
      mode = 2'd1;
      do_start(18'sd0, 18'sd1024);
      wait_hold(h);
      wait_done(n);
      checks++;
      if (n !== 49 || settle_cycles !== 16'd48) begin
         errors++;
         $display("[TB] FAIL fall_settle got n=%0d settle=%0d want 49 48", n, settle_cycles);
      end
      checks++;
      if ({timeout, meas_valid} !== 2'b01) begin
         errors++;
         $display("[TB] FAIL fall_flags got %b want 01", {timeout, meas_valid});
      end
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int h, n;
      mode = 2'd2;
      do_start(18'sd4096, 18'sd2048);
      wait_hold(h);
      wait_done(n);
      checks++;
      if (n !== 1000 || settle_cycles !== 16'd1000) begin
         errors++;
         $display("[TB] FAIL tmo_count got n=%0d settle=%0d want 1000 1000", n, settle_cycles);
      end
      checks++;
      if ({done, timeout, meas_valid} !== 3'b111) begin
         errors++;
         $display("[TB] FAIL tmo_flags got %b want 111", {done, timeout, meas_valid});
      end
      @(negedge clk);
      checks++;
      if ({done, timeout, meas_valid, busy} !== 4'b0110) begin
         errors++;
         $display("[TB] FAIL tmo_after got %b want 0110", {done, timeout, meas_valid, busy});
      end
   endtask

   task automatic test_abort();
      int h, n;
      logic seen;
      mode = 2'd0;
      do_start(18'sd4096, 18'sd2048);
      wait_hold(h);
      repeat (10) @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      checks++;
      if ({model_rst, busy, done, meas_valid} !== 4'b1000 || v_in !== 18'sd0) begin
         errors++;
         $display("[TB] FAIL abort_idle got %b v_in=%0d want 1000 0", {model_rst, busy, done, meas_valid}, v_in);
      end
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1 || meas_valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort_nodone got %b want 0", seen);
      end
      // Abort held across the accepting edge must not affect an IDLE start.
      abort = 1'b1;
      do_start(18'sd4096, 18'sd2048);
      abort = 1'b0;
      wait_hold(h);
      wait_done(n);
      checks++;
      if (h !== 4 || n !== 33 || settle_cycles !== 16'd32) begin
         errors++;
         $display("[TB] FAIL abort_rerun got h=%0d n=%0d settle=%0d want 4 33 32", h, n, settle_cycles);
      end
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      int h, n;
      mode = 2'd0;
      do_start(18'sd4096, 18'sd2048);
      wait_hold(h);
      repeat (5) @(negedge clk);
      #2 rst = 1'b0;
      start = 1'b1;
      #1;
      checks++;
      if ({model_rst, busy, done, timeout, meas_valid} !== 5'b10000 || v_in !== 18'sd0 || settle_cycles !== 16'd0) begin
         errors++;
         $display("[TB] FAIL areset_now got %b v_in=%0d settle=%0d want 10000 0 0",
                  {model_rst, busy, done, timeout, meas_valid}, v_in, settle_cycles);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b1;
      @(negedge clk);
      checks++;
      if ({model_rst, busy, meas_valid} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL areset_release got %b want 100", {model_rst, busy, meas_valid});
      end
      // A start and new operands while busy must not disturb the running step.
      do_start(18'sd4096, 18'sd2048);
      v_step   = 18'sd0;
      v_thresh = -18'sd100;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      wait_hold(h);
      checks++;
      if (h !== 3 || v_in !== 18'sd4096) begin
         errors++;
         $display("[TB] FAIL busy_start got h=%0d v_in=%0d want 3 4096", h, v_in);
      end
      wait_done(n);
      checks++;
      if (n !== 33 || settle_cycles !== 16'd32) begin
         errors++;
         $display("[TB] FAIL busy_result got n=%0d settle=%0d want 33 32", n, settle_cycles);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int h, n;
      mode = 2'd0;
      do_start(18'sd4096, 18'sd2048);
      wait_hold(h);
      wait_done(n);
      @(negedge clk);
      do_start(18'sd4096, 18'sd2048);
      checks++;
      if ({busy, meas_valid, model_rst} !== 3'b101) begin
         errors++;
         $display("[TB] FAIL b2b_accept got %b want 101", {busy, meas_valid, model_rst});
      end
      wait_hold(h);
      wait_done(n);
      checks++;
      if (h !== 4 || n !== 33 || settle_cycles !== 16'd32 || {timeout, meas_valid} !== 2'b01) begin
         errors++;
         $display("[TB] FAIL b2b_result got h=%0d n=%0d settle=%0d flags=%b want 4 33 32 01",
                  h, n, settle_cycles, {timeout, meas_valid});
      end
      @(negedge clk);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst      = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      mode     = 2'd0;
      v_step   = '0;
      v_thresh = '0;
      test_reset();
      test_rising();
      test_falling();
      test_timeout();
      test_abort();
      test_async_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

endmodule
